ram_param: RTL and testbench

//   Parametrised WIDTH x DEPTH word memory with one write port and one independent read port.

---
 rtl/ram_pkg.sv | 19 +
 rtl/ram_clear_ctrl.sv | 66 ++++++
 rtl/ram_param.sv | 90 +++++++++
 tb/tb_ram_param.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
//------------------------------------------------------------------------------
// ram_pkg : shared constants for the ram_param storage block
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package ram_pkg;

  typedef enum logic [0:0] {
    RAM_ST_CLEAR = 1'b0,
    RAM_ST_READY = 1'b1
  } ram_state_e;

  localparam int RAM_DEFAULT_WIDTH = 16;
  localparam int RAM_DEFAULT_DEPTH = 8;

endpackage

`default_nettype wire

// File: rtl/ram_clear_ctrl.sv
//------------------------------------------------------------------------------
// ram_clear_ctrl : post-reset clear sequencer, one word per cycle, owns busy
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH = RAM_DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] c_last = AW'(DEPTH - 1);

  ram_state_e    r_state;
  ram_state_e    w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RAM_ST_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Pointer parks on the last word once clearing is done; only rst rewinds it.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    busy        = 1'b0;
    clr_we      = 1'b0;
    case (r_state)
      RAM_ST_CLEAR: begin
        busy   = 1'b1;
        clr_we = ~rst;
        if (r_ptr == c_last) begin
          w_state_nxt = RAM_ST_READY;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      RAM_ST_READY: begin
        w_state_nxt = RAM_ST_READY;
      end
      default: begin
        w_state_nxt = RAM_ST_CLEAR;
      end
    endcase
  end

  assign clr_addr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/ram_param.sv
//------------------------------------------------------------------------------
// ram_param : WIDTH x DEPTH memory, one write port, one registered read port.
//   RAM_FWD_EN defined selects write-first on same-address collisions.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_param
  import ram_pkg::*;
#(
  parameter int  WIDTH = RAM_DEFAULT_WIDTH,
  parameter int  DEPTH = RAM_DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             busy
);

  localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_clr_we;
  logic [AW-1:0]    w_clr_addr;
  logic             w_waddr_ok;
  logic             w_raddr_ok;
  logic             w_user_we;
  logic             w_mem_we;
  logic [AW-1:0]    w_mem_addr;
  logic [WIDTH-1:0] w_mem_data;
  logic             w_fwd;
  logic [WIDTH-1:0] w_rd_word;

  ram_clear_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign w_waddr_ok = ({1'b0, waddr} < c_depth);
  assign w_raddr_ok = ({1'b0, raddr} < c_depth);
  assign w_user_we  = ~rst & ~busy & we & w_waddr_ok;

  // Clear engine owns the write port while busy; user writes are blocked then.
  assign w_mem_we   = w_clr_we | w_user_we;
  assign w_mem_addr = w_clr_we ? w_clr_addr : waddr;
  assign w_mem_data = w_clr_we ? '0 : wdata;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

`ifdef RAM_FWD_EN
  assign w_fwd = w_user_we & (waddr == raddr);
`else
  assign w_fwd = 1'b0;
`endif

  assign w_rd_word = !w_raddr_ok ? '0 : (w_fwd ? wdata : r_mem[raddr]);

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (busy || !re) begin
      rvalid <= 1'b0;
    end else begin
      rdata  <= w_rd_word;
      rvalid <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_param.sv
//------------------------------------------------------------------------------
// tb_ram_param : directed self-checking bench for ram_param (DEPTH 8 and 6)
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst6 = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic        re = 1'b0;
  logic [2:0]  raddr = '0;
  logic [15:0] rdata, rdata6;
  logic        rvalid, rvalid6;
  logic        busy, busy6;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_param #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .busy(busy)
  );

  ram_param #(.WIDTH(16), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst6), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata6), .rvalid(rvalid6), .busy(busy6)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    re = 1'b1; raddr = a;
    step();
    re = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (busy !== 1'b1 || rvalid !== 1'b0 || rdata !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: busy=%b rvalid=%b rdata=%h, want busy=1 rvalid=0 rdata=0000",
               busy, rvalid, rdata);
    end
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      step();
      n++;
    end
    tests++;
    if (n !== 8) begin
      fails++;
      $display("FAIL reset_busy_len: busy edges=%0d, want 8", n);
    end
    for (int i = 0; i < 8; i++) begin
      rd(3'(i));
      tests++;
      if (rdata !== 16'h0 || rvalid !== 1'b1) begin
        fails++;
        $display("FAIL reset_clear_word%0d: rdata=%h rvalid=%b, want 0000/1", i, rdata, rvalid);
      end
    end
  endtask

  task automatic test_basic();
    wr(3'd3, 16'hA5A5);
    rd(3'd3);
    tests++;
    if (rdata !== 16'hA5A5 || rvalid !== 1'b1) begin
      fails++;
      $display("FAIL basic_read: rdata=%h rvalid=%b, want a5a5/1", rdata, rvalid);
    end
    step();
    tests++;
    if (rdata !== 16'hA5A5 || rvalid !== 1'b0) begin
      fails++;
      $display("FAIL basic_hold: rdata=%h rvalid=%b, want a5a5/0", rdata, rvalid);
    end
  endtask

  task automatic test_collision();
    logic [15:0] exp;
`ifdef RAM_FWD_EN
    exp = 16'h2222;
`else
    exp = 16'h1111;
`endif
    wr(3'd5, 16'h1111);
    we = 1'b1; waddr = 3'd5; wdata = 16'h2222;
    re = 1'b1; raddr = 3'd5;
    step();
    we = 1'b0; re = 1'b0;
    tests++;
    if (rdata !== exp || rvalid !== 1'b1) begin
      fails++;
      $display("FAIL collision_same_edge: rdata=%h rvalid=%b, want %h/1", rdata, rvalid, exp);
    end
    rd(3'd5);
    tests++;
    if (rdata !== 16'h2222) begin
      fails++;
      $display("FAIL collision_after: rdata=%h, want 2222", rdata);
    end
    // independent ports at the same edge
    we = 1'b1; waddr = 3'd6; wdata = 16'h3333;
    re = 1'b1; raddr = 3'd3;
    step();
    we = 1'b0; re = 1'b0;
    tests++;
    if (rdata !== 16'hA5A5 || rvalid !== 1'b1) begin
      fails++;
      $display("FAIL independent_read: rdata=%h rvalid=%b, want a5a5/1", rdata, rvalid);
    end
    rd(3'd6);
    tests++;
    if (rdata !== 16'h3333) begin
      fails++;
      $display("FAIL independent_write: rdata=%h, want 3333", rdata);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    for (int i = 0; i < 4; i++) wr(3'(i), 16'hFFFF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL midclear_busy: busy=%b, want 1", busy);
    end
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      step();
      n++;
    end
    tests++;
    if (n !== 8) begin
      fails++;
      $display("FAIL midclear_busy_len: busy edges=%0d, want 8", n);
    end
    for (int i = 0; i < 8; i++) begin
      rd(3'(i));
      tests++;
      if (rdata !== 16'h0 || rvalid !== 1'b1) begin
        fails++;
        $display("FAIL midclear_word%0d: rdata=%h rvalid=%b, want 0000/1", i, rdata, rvalid);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    int bad;
    rst = 1'b1;
    step();
    rst = 1'b0;
    we = 1'b1; waddr = 3'd2; wdata = 16'hBEEF;
    re = 1'b1; raddr = 3'd2;
    n = 0;
    bad = 0;
    while (busy === 1'b1 && n < 20) begin
      step();
      n++;
      if (rvalid !== 1'b0) bad++;
    end
    we = 1'b0; re = 1'b0;
    tests++;
    if (bad !== 0 || n !== 8) begin
      fails++;
      $display("FAIL busy_rvalid: rvalid-high edges=%0d busy edges=%0d, want 0 and 8", bad, n);
    end
    rd(3'd2);
    tests++;
    if (rdata !== 16'h0 || rvalid !== 1'b1) begin
      fails++;
      $display("FAIL busy_write_dropped: rdata=%h rvalid=%b, want 0000/1", rdata, rvalid);
    end
  endtask

  task automatic test_depth6();
    int n;
    rst6 = 1'b1;
    step();
    rst6 = 1'b0;
    n = 0;
    while (busy6 === 1'b1 && n < 20) begin
      step();
      n++;
    end
    tests++;
    if (n !== 6) begin
      fails++;
      $display("FAIL d6_busy_len: busy edges=%0d, want 6", n);
    end
    for (int i = 0; i < 6; i++) wr(3'(i), 16'h0100 + 16'(i));
    wr(3'd6, 16'h7777);
    wr(3'd7, 16'h8888);
    rd(3'd6);
    tests++;
    if (rdata6 !== 16'h0 || rvalid6 !== 1'b1) begin
      fails++;
      $display("FAIL d6_oob_read6: rdata=%h rvalid=%b, want 0000/1", rdata6, rvalid6);
    end
    rd(3'd7);
    tests++;
    if (rdata6 !== 16'h0 || rvalid6 !== 1'b1) begin
      fails++;
      $display("FAIL d6_oob_read7: rdata=%h rvalid=%b, want 0000/1", rdata6, rvalid6);
    end
    for (int i = 0; i < 6; i++) begin
      rd(3'(i));
      tests++;
      if (rdata6 !== 16'h0100 + 16'(i) || rvalid6 !== 1'b1) begin
        fails++;
        $display("FAIL d6_word%0d: rdata=%h rvalid=%b, want %h/1",
                 i, rdata6, rvalid6, 16'h0100 + 16'(i));
      end
    end
  endtask

  initial begin
    step();
    test_reset();
    test_basic();
    test_collision();
    test_reset_mid_clear();
    test_busy_ignore();
    test_depth6();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
